// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Instruction register field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int OFF_MSB = 15;
    localparam int OFF_LSB = 0;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Word-align an address by clearing the byte-offset bits.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// Splits an instruction word into its opcode/rs/rt/offset fields.
// Pure wiring, no sign extension; also reused by control decode.
module instr_field_split
    import fetch_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] offset
);

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign rs     = ir[RS_MSB:RS_LSB];
    assign rt     = ir[RT_MSB:RT_LSB];
    assign offset = ir[OFF_MSB:OFF_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: issues a read of the PC, waits a fixed
// memory latency, captures the word into IR and holds it under valid/ready.
// A redirect reloads the PC and abandons any fetch in flight.
//
//   state | meaning
//   FETCH | mem_rd strobe for PC, latency counter loaded
//   WAIT  | counting down; IR captured on the edge where counter = 1
//   HOLD  | IR valid, waiting for the consumer to accept
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          MEM_LATENCY = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] offset,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      pc_out_q, pc_out_d;

    // Next-state logic; redirect overrides everything the FSM would do.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        pc_out_d = pc_out_q;

        if (redirect) begin
            pc_d    = align_pc(redirect_pc);
            state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH: begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        ir_d     = mem_data;
                        pc_out_d = pc_q;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = HOLD;
                    end else begin
                        cnt_d = cnt_q - CNT_LAST;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // State, counter, PC and instruction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            cnt_q    <= '0;
            pc_q     <= align_pc(RESET_PC);
            ir_q     <= '0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
        end
    end

    // The reset state is FETCH, so the strobe is masked while reset is held
    // to keep memory quiet until the first real cycle.
    assign mem_rd      = (state_q == FETCH) && reset;
    assign mem_addr    = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + PC_STEP;

    instr_field_split u_split (
        .ir     (ir_q),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .offset (offset)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a cycle-level reference model
// pushes expected fetches, valid bits and instructions; a monitor pops them.
module tb_instr_fetch_unit;

    localparam int          LAT    = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] offset;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    instr_fetch_unit #(.MEM_LATENCY(LAT), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .offset      (offset),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int cyc; logic [31:0] pc; } fetch_exp_t;
    typedef struct { int cyc; logic [31:0] pc; logic [31:0] word; } instr_exp_t;
    typedef struct { int due; logic [31:0] addr; } rd_t;

    fetch_exp_t fetch_q[$];
    instr_exp_t instr_q[$];
    bit         valid_q[$];
    rd_t        rd_q[$];

    int vectors;
    int miscompares;
    int cyc;
    bit mon_en;

    // reference model: PC of the instruction in flight/held, and the cycles
    // at which its fetch strobe and its valid are due
    logic [31:0] m_pc;
    int          fetch_cycle;
    int          valid_from;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h8C22_0010;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    task automatic check_reset_values(input string tag);
        check32({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        check32({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check32({tag, "_mem_addr"}, mem_addr, RST_PC);
        check32({tag, "_opcode"}, 32'(opcode), 32'd0);
        check32({tag, "_rs"}, 32'(rs), 32'd0);
        check32({tag, "_rt"}, 32'(rt), 32'd0);
        check32({tag, "_offset"}, 32'(offset), 32'd0);
        check32({tag, "_pc_out"}, pc_out, 32'd0);
        check32({tag, "_pc_plus4"}, pc_plus4, 32'd4);
    endtask

    task automatic model_init;
        fetch_exp_t fe;
        cyc         = 0;
        m_pc        = RST_PC;
        fetch_cycle = 0;
        valid_from  = LAT + 1;
        valid_q.push_back(1'b0);
        fe.cyc = 0;
        fe.pc  = RST_PC;
        fetch_q.push_back(fe);
    endtask

    // Asserts reset (if not already), checks reset values, then releases it
    // mid high phase so the first negedge sampled is cycle 0.
    task automatic do_reset(input string tag);
        mon_en      = 1'b0;
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        mem_data    = '0;
        #3;
        check_reset_values(tag);
        repeat (2) @(posedge clk);
        #1;
        check_reset_values({tag, "_held"});
        fetch_q.delete();
        instr_q.delete();
        valid_q.delete();
        rd_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_init();
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    // One cycle: memory model, input drive, model update, expectations for
    // the next cycle. Called at the negedge, returns at the next negedge.
    task automatic step(input bit r, input logic [31:0] tgt, input bit y);
        fetch_exp_t fe;
        instr_exp_t ie;
        rd_t        rd;
        bit         held;

        if (mem_rd) begin
            rd.due  = cyc + LAT;
            rd.addr = mem_addr;
            rd_q.push_back(rd);
        end
        mem_data = $urandom;
        for (int i = rd_q.size() - 1; i >= 0; i--) begin
            if (rd_q[i].due == cyc) begin
                mem_data = mem_word(rd_q[i].addr);
                rd_q.delete(i);
            end
        end

        redirect    = r;
        redirect_pc = tgt;
        instr_ready = y;

        held = (cyc >= valid_from);
        if (r) begin
            m_pc        = tgt & 32'hFFFF_FFFC;
            fetch_cycle = cyc + 1;
            valid_from  = cyc + 2 + LAT;
        end else if (held && y) begin
            m_pc        = m_pc + 32'd4;
            fetch_cycle = cyc + 1;
            valid_from  = cyc + 2 + LAT;
        end

        valid_q.push_back(cyc + 1 >= valid_from);
        if (fetch_cycle == cyc + 1) begin
            fe.cyc = cyc + 1;
            fe.pc  = m_pc;
            fetch_q.push_back(fe);
        end
        if (valid_from == cyc + 1) begin
            ie.cyc  = cyc + 1;
            ie.pc   = m_pc;
            ie.word = mem_word(m_pc);
            instr_q.push_back(ie);
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_held;
        int n;
        n = 0;
        while (cyc < valid_from && n < 50) begin
            step(1'b0, 32'h0, 1'b0);
            n++;
        end
        if (cyc < valid_from) fail_event("wait_held_timeout");
    endtask

    // Monitor: pops expectations whenever the DUT presents an output.
    initial begin
        bit         prev_valid;
        bit         ev;
        fetch_exp_t fe;
        instr_exp_t ie;
        instr_exp_t held_e;
        prev_valid = 1'b0;
        held_e.cyc = 0;
        held_e.pc = '0;
        held_e.word = '0;
        forever begin
            @(negedge clk);
            if (!mon_en || !reset) begin
                prev_valid = 1'b0;
                continue;
            end

            if (valid_q.size() == 0) begin
                fail_event("valid_queue_empty");
            end else begin
                ev = valid_q.pop_front();
                check32("instr_valid", 32'(instr_valid), 32'(ev));
            end

            if (mem_rd) begin
                if (fetch_q.size() == 0) begin
                    fail_event("mem_rd_unexpected");
                end else begin
                    fe = fetch_q.pop_front();
                    check32("fetch_cycle", cyc, fe.cyc);
                    check32("mem_addr", mem_addr, fe.pc);
                end
            end else if (fetch_q.size() > 0 && fetch_q[0].cyc <= cyc) begin
                fe = fetch_q.pop_front();
                check32("mem_rd_missing", 32'(mem_rd), 32'd1);
            end

            if (instr_valid && !prev_valid) begin
                if (instr_q.size() == 0) begin
                    fail_event("instr_unexpected");
                end else begin
                    ie = instr_q.pop_front();
                    held_e = ie;
                    check32("valid_cycle", cyc, ie.cyc);
                end
            end else if (!instr_valid && instr_q.size() > 0 && instr_q[0].cyc <= cyc) begin
                ie = instr_q.pop_front();
                check32("instr_missing", 32'(instr_valid), 32'd1);
            end

            if (instr_valid) begin
                check32("pc_out", pc_out, held_e.pc);
                check32("pc_plus4", pc_plus4, held_e.pc + 32'd4);
                check32("opcode", 32'(opcode), 32'(held_e.word[31:26]));
                check32("rs", 32'(rs), 32'(held_e.word[25:21]));
                check32("rt", 32'(rt), 32'(held_e.word[20:16]));
                check32("offset", 32'(offset), 32'(held_e.word[15:0]));
            end
            prev_valid = instr_valid;
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        reset       = 1'b0;
        cyc         = 0;

        do_reset("rst");
        check32("first_mem_rd", 32'(mem_rd), 32'd1);
        check32("first_mem_addr", mem_addr, 32'h0);

        repeat (3) step(1'b0, 32'h0, 1'b0);
        check32("first_valid", 32'(instr_valid), 32'd1);
        check32("first_opcode", 32'(opcode), 32'h23);
        check32("first_rs", 32'(rs), 32'd1);
        check32("first_rt", 32'(rt), 32'd2);
        check32("first_offset", 32'(offset), 32'h0010);
        check32("first_pc_out", pc_out, 32'h0);
        check32("first_pc_plus4", pc_plus4, 32'h4);

        // back-pressure, then accept
        repeat (10) step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        check32("bp_mem_rd", 32'(mem_rd), 32'd1);
        check32("bp_mem_addr", mem_addr, 32'h4);

        // redirect while waiting on memory
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0103, 1'b0);
        check32("redir_mem_rd", 32'(mem_rd), 32'd1);
        check32("redir_mem_addr", mem_addr, 32'h0000_0100);

        // redirect coinciding with accept
        wait_held();
        step(1'b1, 32'h0000_0200, 1'b1);
        check32("redir_acc_mem_addr", mem_addr, 32'h0000_0200);

        // PC wrap
        step(1'b1, 32'hFFFF_FFFC, 1'b0);
        wait_held();
        check32("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        check32("wrap_pc_plus4", pc_plus4, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        check32("wrap_mem_addr", mem_addr, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 15) == 0, $urandom, 1'($urandom_range(0, 1)));
        end

        // async reset in HOLD, away from the clock edge
        step(1'b0, 32'h0, 1'b0);
        wait_held();
        step(1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        check32("pre_reset_valid", 32'(instr_valid), 32'd1);
        #1;
        do_reset("midrst");

        wait_held();
        step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 7) == 0, $urandom, 1'($urandom_range(0, 1)));
        end

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
